// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: rate-1/2 feed-forward convolutional encoder with a zero tail.
// One info bit per handshake becomes two serial symbols (G0 then G1) on
// consecutive clocks. After the frame's last bit, K-1 zero bits are flushed so
// the decoder trellis finishes in state 0.
module conv_encoder_tx #(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic din,
    input  logic din_valid,
    input  logic din_last,
    output logic din_ready,
    output logic y,
    output logic y_valid,
    output logic c,
    output logic y_sof,
    output logic y_eof,
    output logic busy
);

    localparam int TAIL = K - 1;
    localparam int CW   = (TAIL > 1) ? $clog2(TAIL) : 1;
    localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYM0  = 3'd1,
        SYM1  = 3'd2,
        WAIT  = 3'd3,
        TAIL0 = 3'd4,
        TAIL1 = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [K-2:0]    sr_reg;            // previous K-1 bits, newest at MSB
    logic            p0_reg, p1_reg;    // symbols of the bit being emitted
    logic            tail_pending_reg;  // last bit accepted, tail follows
    logic [CW-1:0]   tail_cnt_reg;
    logic            sof_reg;           // current pair starts the frame

    logic            accept;
    logic            encode;
    logic            bit_in;
    logic [K-1:0]    w;
    logic [K-1:0]    tap0, tap1;
    logic            p0, p1;

    assign accept = din_valid && din_ready;
    // Tail bits are encoded as zeros; only a real handshake injects din.
    assign bit_in = accept ? din : 1'b0;
    assign encode = accept || (state_next == TAIL0);
    assign w      = {bit_in, sr_reg};

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_tap
            assign tap0[gi] = w[gi] & G0[gi];
            assign tap1[gi] = w[gi] & G1[gi];
        end
    endgenerate

    assign p0 = ^tap0;
    assign p1 = ^tap1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SYM0;
            SYM0:    state_next = SYM1;
            SYM1: begin
                if (tail_pending_reg)  state_next = TAIL0;
                else if (accept)       state_next = SYM0;
                else                   state_next = WAIT;
            end
            WAIT:    if (accept) state_next = SYM0;
            TAIL0:   state_next = TAIL1;
            TAIL1: begin
                if (tail_cnt_reg < TAIL_LAST) state_next = TAIL0;
                else                          state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Encoder datapath: latch the symbol pair and advance the shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_reg           <= '0;
            p0_reg           <= 1'b0;
            p1_reg           <= 1'b0;
            tail_pending_reg <= 1'b0;
            tail_cnt_reg     <= '0;
            sof_reg          <= 1'b0;
        end else begin
            if (encode) begin
                p0_reg <= p0;
                p1_reg <= p1;
                sr_reg <= {bit_in, sr_reg[K-2:1]};
            end else if (state_next == IDLE) begin
                sr_reg <= '0;
            end

            if (accept && din_last) begin
                tail_pending_reg <= 1'b1;
            end else if (state_next == IDLE) begin
                tail_pending_reg <= 1'b0;
            end

            if (state_reg == TAIL1 && state_next == TAIL0) begin
                tail_cnt_reg <= tail_cnt_reg + CW'(1);
            end else if (state_next == IDLE) begin
                tail_cnt_reg <= '0;
            end

            if (accept) begin
                sof_reg <= (state_reg == IDLE);
            end
        end
    end

    // Output decode from state and latched symbols
    always_comb begin
        din_ready = (state_reg == IDLE) || (state_reg == WAIT) ||
                    ((state_reg == SYM1) && !tail_pending_reg);
        busy      = (state_reg != IDLE);
        y         = 1'b0;
        y_valid   = 1'b0;
        c         = 1'b0;
        y_sof     = 1'b0;
        y_eof     = 1'b0;
        case (state_reg)
            SYM0: begin
                y       = p0_reg;
                y_valid = 1'b1;
                y_sof   = sof_reg;
            end
            SYM1: begin
                y       = p1_reg;
                y_valid = 1'b1;
                c       = 1'b1;
            end
            TAIL0: begin
                y       = p0_reg;
                y_valid = 1'b1;
            end
            TAIL1: begin
                y       = p1_reg;
                y_valid = 1'b1;
                c       = 1'b1;
                y_eof   = (tail_cnt_reg == TAIL_LAST);
            end
            default: begin
                y_valid = 1'b0;
            end
        endcase
    end

endmodule
